rect_fill_engine: RTL and testbench
===================================

# rect_fill_engine

Parametrised rectangle-fill engine that drives the VGA adapter's pixel-write port with a start/busy/done handshake. It latches an origin, size, colour and erase flag, then emits one pixel per clock in raster order. Pixels outside the visible screen are clipped, not plotted. It sits between the game controller, which issues press and garbage draw/erase requests, and the VGA adapter's x/y/colour/writeEn inputs.

## Interface
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- DIM_W, 6, width/height field width; sizes range 0..2^DIM_W-1
- C_W, 3, colour width
- SCREEN_W, 160, visible columns; x >= SCREEN_W is clipped
- SCREEN_H, 120, visible rows; y >= SCREEN_H is clipped
- ERASE_COLOUR, 0, colour driven when the erase flag is latched

- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- start  in  1  request pulse; sampled only in IDLE
- x0  in  X_W  rectangle origin column
- y0  in  Y_W  rectangle origin row
- rect_w  in  DIM_W  rectangle width in pixels
- rect_h  in  DIM_W  rectangle height in pixels
- colour_in  in  C_W  fill colour
- erase  in  1  1 = fill with ERASE_COLOUR instead of colour_in
- busy  out  1  high in DRAW
- done  out  1  one-cycle pulse when a request completes
- x_out  out  X_W  pixel column to the VGA adapter
- y_out  out  Y_W  pixel row to the VGA adapter
- colour_out  out  C_W  pixel colour
- plot  out  1  VGA writeEn

## Operation
- States: IDLE, DRAW, FINISH.
- IDLE with start=1:
  - Latch x0, y0, rect_w, rect_h, and the effective colour (erase ? ERASE_COLOUR : colour_in).
  - Clear column counter cx and row counter cy (both DIM_W bits).
  - If rect_w==0 or rect_h==0, go to FINISH with no pixels plotted. Otherwise go to DRAW.
- DRAW, each cycle:
  - Register x_out = x0+cx and y_out = y0+cy.
  - Compute sums at X_W+1 and Y_W+1 bits; no wrap-around is allowed.
  - Assert plot=1 only if both sums are below SCREEN_W and SCREEN_H respectively; otherwise plot=0.
  - Counters always advance, so clipped pixels still consume their cycle.
- Counter advance:
  - If cx < w-1: cx++.
  - Else if cy < h-1: cx=0, cy++.
  - Else: go to FINISH.
- FINISH: done=1 for exactly one cycle, plot=0, then return to IDLE.
- start is ignored in DRAW and FINISH; no queueing.
- Input changes after the latch cycle have no effect on the request in progress.
- Reset (any state): state=IDLE, all counters cleared, x_out=0, y_out=0, colour_out=0, plot=0, busy=0, done=0. A request aborted by reset produces no done.

## Timing
- All outputs are registered.
- Cycle 0: start is sampled in IDLE.
- Cycles 1 .. W*H: exactly one pixel per cycle in DRAW. The pixel (cx,cy) appears at cycle 1 + cy*W + cx.
- busy=1 from cycle 1 through cycle W*H.
- Cycle W*H+1: done=1, busy=0. A new start is accepted from cycle W*H+2.
- Zero-size request: done at cycle 1, busy never asserted.
- Throughput: W*H+2 cycles per request, including the start cycle.

## Test plan
- Reset, then x0=0, y0=0, w=40, h=60, colour_in=7, erase=0:
  - 2400 plot cycles, colour 7.
  - First pixel (0,0), last pixel (39,59).
  - done at cycle 2401.
- Garbage-style request x0=130, y0=100, w=20, h=20, erase=1:
  - 400 cycles of colour 0.
  - Pixels span (130..149, 100..119).
- Clipping, x0=150, y0=115, w=20, h=10:
  - 200 DRAW cycles.
  - plot=1 only for x 150..159 and y 115..119, i.e. 50 pixels.
  - No coordinate wraps.
  - done at cycle 201.
- Zero size, w=0, h=5:
  - No plot.
  - done at cycle 1, busy stays 0.
- Second start mid-draw with different inputs:
  - Ignored; the original rectangle completes unchanged.
  - A start at cycle W*H+2 is accepted.
- reset_n low at pixel 100 of a 40x60 request:
  - Next cycle: all outputs 0, state IDLE.
  - No done pulse.
  - A fresh start then draws correctly from (x0,y0).

Source files
------------

// File: rtl/rect_fill_engine.sv
// Rectangle-fill engine: latches origin/size/colour on start, then emits one
// pixel per clock in raster order to the VGA write port, clipping off-screen pixels.
module rect_fill_engine #(
  parameter int X_W          = 8,
  parameter int Y_W          = 7,
  parameter int DIM_W        = 6,
  parameter int C_W          = 3,
  parameter int SCREEN_W     = 160,
  parameter int SCREEN_H     = 120,
  parameter int ERASE_COLOUR = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [X_W-1:0]   x0,
  input  logic [Y_W-1:0]   y0,
  input  logic [DIM_W-1:0] rect_w,
  input  logic [DIM_W-1:0] rect_h,
  input  logic [C_W-1:0]   colour_in,
  input  logic             erase,
  output logic             busy,
  output logic             done,
  output logic [X_W-1:0]   x_out,
  output logic [Y_W-1:0]   y_out,
  output logic [C_W-1:0]   colour_out,
  output logic             plot
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAW   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [X_W-1:0]   x0_q, x0_d;
  logic [Y_W-1:0]   y0_q, y0_d;
  logic [DIM_W-1:0] w_q, w_d;
  logic [DIM_W-1:0] h_q, h_d;
  logic [DIM_W-1:0] cx_q, cx_d;
  logic [DIM_W-1:0] cy_q, cy_d;
  logic [C_W-1:0]   colour_q, colour_d;
  logic [X_W-1:0]   x_out_q, x_out_d;
  logic [Y_W-1:0]   y_out_q, y_out_d;
  logic             plot_q, plot_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             draw_px_s;
  logic [X_W:0]     x_sum_s;
  logic [Y_W:0]     y_sum_s;

  // Next-state, counter advance and registered-output computation.
  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    w_d       = w_q;
    h_d       = h_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    colour_d  = colour_q;
    x_out_d   = x_out_q;
    y_out_d   = y_out_q;
    plot_d    = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    draw_px_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x0_d     = x0;
          y0_d     = y0;
          w_d      = rect_w;
          h_d      = rect_h;
          cx_d     = {DIM_W{1'b0}};
          cy_d     = {DIM_W{1'b0}};
          colour_d = erase ? C_W'(ERASE_COLOUR) : colour_in;
          if ((rect_w == {DIM_W{1'b0}}) || (rect_h == {DIM_W{1'b0}})) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d   = ST_DRAW;
            busy_d    = 1'b1;
            draw_px_s = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAW: begin
        // cx_q/cy_q name the pixel currently on the outputs; step to the next one.
        if (cx_q != (w_q - DIM_W'(1))) begin
          cx_d      = cx_q + DIM_W'(1);
          busy_d    = 1'b1;
          draw_px_s = 1'b1;
        end else if (cy_q != (h_q - DIM_W'(1))) begin
          cx_d      = {DIM_W{1'b0}};
          cy_d      = cy_q + DIM_W'(1);
          busy_d    = 1'b1;
          draw_px_s = 1'b1;
        end else begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Sums are one bit wider than the coordinate so off-screen pixels never alias on-screen.
    x_sum_s = {1'b0, x0_d} + (X_W+1)'(cx_d);
    y_sum_s = {1'b0, y0_d} + (Y_W+1)'(cy_d);
    if (draw_px_s) begin
      x_out_d = x_sum_s[X_W-1:0];
      y_out_d = y_sum_s[Y_W-1:0];
      plot_d  = (x_sum_s < (X_W+1)'(SCREEN_W)) && (y_sum_s < (Y_W+1)'(SCREEN_H));
    end else begin
      plot_d = 1'b0;
    end
  end

  // State, request latches and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      x0_q     <= {X_W{1'b0}};
      y0_q     <= {Y_W{1'b0}};
      w_q      <= {DIM_W{1'b0}};
      h_q      <= {DIM_W{1'b0}};
      cx_q     <= {DIM_W{1'b0}};
      cy_q     <= {DIM_W{1'b0}};
      colour_q <= {C_W{1'b0}};
      x_out_q  <= {X_W{1'b0}};
      y_out_q  <= {Y_W{1'b0}};
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      colour_q <= colour_d;
      x_out_q  <= x_out_d;
      y_out_q  <= y_out_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign colour_out = colour_q;
  assign plot       = plot_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: directed and random requests
// compared against a raster/clipping reference model.
module tb_rect_fill_engine;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [5:0] rect_w;
  logic [5:0] rect_h;
  logic [2:0] colour_in;
  logic       erase;
  logic       busy;
  logic       done;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot;

  int errors = 0;
  int checks = 0;

  rect_fill_engine dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .x0         (x0),
    .y0         (y0),
    .rect_w     (rect_w),
    .rect_h     (rect_h),
    .colour_in  (colour_in),
    .erase      (erase),
    .busy       (busy),
    .done       (done),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .plot       (plot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Number of on-screen pixels of a rectangle, from interval overlap.
  function automatic int visible_count(input int ax, input int ay, input int w, input int h);
    int vx, vy;
    vx = ((ax + w) < 160 ? (ax + w) : 160) - ax;
    vy = ((ay + h) < 120 ? (ay + h) : 120) - ay;
    if (vx < 0) vx = 0;
    if (vy < 0) vy = 0;
    return vx * vy;
  endfunction

  // Issue one request and check every cycle through the return to IDLE.
  task automatic run_req(input int ax, input int ay, input int w, input int h,
                         input int col, input bit er, input bit mid_start);
    int n, ex, ey, ecol, nplot, nvis, t;
    n    = w * h;
    ecol = er ? 0 : col;
    nvis = visible_count(ax, ay, w, h);
    x0 = 8'(ax); y0 = 7'(ay); rect_w = 6'(w); rect_h = 6'(h);
    colour_in = 3'(col); erase = er; start = 1'b1;
    step();
    start = 1'b0;
    if (n == 0) begin
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      chk("zero_plot", plot, 0);
      step();
      chk("zero_done_clr", done, 0);
      chk("zero_busy_idle", busy, 0);
      return;
    end
    nplot = 0;
    for (int k = 0; k < n; k++) begin
      ex = ax + (k % w);
      ey = ay + (k / w);
      chk("draw_busy", busy, 1);
      chk("draw_done", done, 0);
      chk("draw_plot", plot, ((ex < 160) && (ey < 120)) ? 1 : 0);
      if ((ex < 160) && (ey < 120)) begin
        chk("draw_x", x_out, ex);
        chk("draw_y", y_out, ey);
        chk("draw_colour", colour_out, ecol);
      end
      if (plot) nplot++;
      if (mid_start && k == 3) begin
        t = $urandom;
        start = 1'b1; x0 = 8'(t); y0 = 7'(t >> 8); rect_w = 6'(t >> 15);
        rect_h = 6'(t >> 21); colour_in = 3'(~col); erase = ~er;
      end else begin
        start = 1'b0;
      end
      step();
    end
    chk("fin_done", done, 1);
    chk("fin_busy", busy, 0);
    chk("fin_plot", plot, 0);
    chk("plot_count", nplot, nvis);
    step();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int w, h;
    reset_n = 1'b0; start = 1'b0; x0 = 8'd0; y0 = 7'd0;
    rect_w = 6'd0; rect_h = 6'd0; colour_in = 3'd0; erase = 1'b0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_plot", plot, 0);
    chk("rst_x", x_out, 0);
    chk("rst_y", y_out, 0);
    chk("rst_colour", colour_out, 0);
    reset_n = 1'b1;
    step();

    run_req(0, 0, 40, 60, 7, 1'b0, 1'b0);
    run_req(130, 100, 20, 20, 5, 1'b1, 1'b0);
    run_req(150, 115, 20, 10, 2, 1'b0, 1'b0);
    run_req(10, 10, 0, 5, 4, 1'b0, 1'b0);
    run_req(10, 10, 5, 0, 4, 1'b0, 1'b0);
    // Mid-draw start ignored, then a back-to-back request at W*H+2.
    run_req(10, 20, 8, 5, 3, 1'b0, 1'b1);
    run_req(100, 50, 3, 4, 6, 1'b0, 1'b0);

    // Reset while pixel 100 of a 40x60 request is on the outputs.
    x0 = 8'd5; y0 = 7'd7; rect_w = 6'd40; rect_h = 6'd60;
    colour_in = 3'd6; erase = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 100; k++) step();
    chk("pre_rst_x", x_out, 5 + (100 % 40));
    chk("pre_rst_y", y_out, 7 + (100 / 40));
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_plot", plot, 0);
    chk("abort_x", x_out, 0);
    chk("abort_y", y_out, 0);
    chk("abort_colour", colour_out, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("abort_no_done", done, 0);
      chk("abort_idle_busy", busy, 0);
    end
    run_req(5, 7, 40, 60, 6, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      w = $urandom_range(0, 40);
      h = $urandom_range(0, 40);
      run_req($urandom_range(0, 255), $urandom_range(0, 127), w, h,
              $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
